// File: rtl/ssd_scan_driver_pkg.sv
// Shared seven-segment code points (also used by the lock FSM) and glyph constants.
package ssd_scan_driver_pkg;

  typedef logic [4:0] ssd_code_t;
  typedef logic [6:0] ssd_glyph_t;

  localparam ssd_code_t SSD_BLANK = 5'd0;
  localparam ssd_code_t SSD_A     = 5'd10;
  localparam ssd_code_t SSD_B     = 5'd11;
  localparam ssd_code_t SSD_E     = 5'd12;
  localparam ssd_code_t SSD_C     = 5'd13;
  localparam ssd_code_t SSD_L     = 5'd14;
  localparam ssd_code_t SSD_DASH  = 5'd15;
  localparam ssd_code_t SSD_D     = 5'd16;
  localparam ssd_code_t SSD_O     = 5'd17;
  localparam ssd_code_t SSD_P     = 5'd18;
  localparam ssd_code_t SSD_N     = 5'd19;
  localparam ssd_code_t SSD_U     = 5'd20;

  // Active-low {g,f,e,d,c,b,a}; all ones means every segment off.
  localparam ssd_glyph_t GLYPH_BLANK = 7'h7F;
  localparam logic [3:0] AN_ALL_OFF  = 4'b1111;

  // Codes 1..9 are the decimal digits themselves.
  function automatic ssd_code_t digit_code(input logic [3:0] value);
    return (value <= 4'd9) ? ssd_code_t'(value) : SSD_BLANK;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_glyph_rom.sv
// Combinational 5-bit display code to active-low segment pattern.
module ssd_glyph_rom
  import ssd_scan_driver_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_BLANK;
    case (code_i)
      5'd1:     glyph_o = 7'h79;
      5'd2:     glyph_o = 7'h24;
      5'd3:     glyph_o = 7'h30;
      5'd4:     glyph_o = 7'h19;
      5'd5:     glyph_o = 7'h12;
      5'd6:     glyph_o = 7'h02;
      5'd7:     glyph_o = 7'h78;
      5'd8:     glyph_o = 7'h00;
      5'd9:     glyph_o = 7'h10;
      SSD_A:    glyph_o = 7'h08;
      SSD_B:    glyph_o = 7'h03;
      SSD_E:    glyph_o = 7'h06;
      SSD_C:    glyph_o = 7'h46;
      SSD_L:    glyph_o = 7'h47;
      SSD_DASH: glyph_o = 7'h3F;
      SSD_D:    glyph_o = 7'h21;
      SSD_O:    glyph_o = 7'h40;
      SSD_P:    glyph_o = 7'h0C;
      SSD_N:    glyph_o = 7'h2B;
      SSD_U:    glyph_o = 7'h41;
      default:  glyph_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver: frame-coherent shadow of the ssd word,
// one anode per refresh slot, optional per-digit blink.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  AN,
  output logic [6:0]  seven_out
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [1:0]    idx_q, idx_d;
  logic [19:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          tick;
  logic          blink_wrap;
  logic          suppress;
  logic [4:0]    digit_code_w [4];
  logic [4:0]    cur_code;
  logic [6:0]    cur_glyph;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_code_w[gi] = shadow_q[5*gi +: 5];
  end

  assign tick       = (refresh_cnt_q == REFRESH_LAST);
  assign blink_wrap = (blink_cnt_q == BLINK_LAST);
  assign cur_code   = digit_code_w[idx_q];
  assign suppress   = blink_mask[idx_q] & blink_phase_q;

  ssd_glyph_rom u_glyph_rom (
    .code_i  (cur_code),
    .glyph_o (cur_glyph)
  );

  always_comb begin
    refresh_cnt_d = tick ? '0 : refresh_cnt_q + 1'b1;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    // Latch only at the last slot so the coming frame shows one coherent word.
    shadow_d      = (tick && idx_q == 2'd3) ? ssd : shadow_q;
    an_d          = suppress ? AN_ALL_OFF : ~(4'b0001 << idx_q);
    seg_d         = suppress ? GLYPH_BLANK : cur_glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      idx_q         <= 2'd0;
      shadow_q      <= 20'd0;
      an_q          <= AN_ALL_OFF;
      seg_q         <= GLYPH_BLANK;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign AN        = an_q;
  assign seven_out = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomised bench for ssd_scan_driver: two instances (4/16 and 1/3 dividers)
// checked every cycle against a cycle-count model, plus literal pins.
module tb_ssd_scan_driver;

  localparam int R0 = 4;
  localparam int B0 = 16;
  localparam int R1 = 1;
  localparam int B1 = 3;

  localparam logic [6:0] GLYPH_TAB [0:31] = '{
    7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h06, 7'h46, 7'h47, 7'h3F,
    7'h21, 7'h40, 7'h0C, 7'h2B, 7'h41, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ssd;
  logic [3:0]  blink_mask;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;

  int checks = 0;
  int passes = 0;

  // Model state: cycles since reset and the word the display currently shows.
  int          c0 = 0, c1 = 0;
  logic [19:0] sh0 = '0, sh1 = '0;
  logic [3:0]  exp_an0, exp_an1;
  logic [6:0]  exp_seg0, exp_seg1;
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.REFRESH_DIV(R0), .BLINK_DIV(B0)) dut0 (
    .clk(clk), .rst(rst), .ssd(ssd), .blink_mask(blink_mask),
    .AN(an0), .seven_out(seg0)
  );

  ssd_scan_driver #(.REFRESH_DIV(R1), .BLINK_DIV(B1)) dut1 (
    .clk(clk), .rst(rst), .ssd(ssd), .blink_mask(blink_mask),
    .AN(an1), .seven_out(seg1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  // What the display shows during cycle c: slot (c/r)%4, blink phase (c/b)%2.
  function automatic void model_out(input int c, input int r, input int b,
                                    input logic [19:0] sh, input logic [3:0] mask,
                                    output logic [3:0] an, output logic [6:0] seg);
    int idx;
    logic [4:0] code;
    idx  = (c / r) % 4;
    code = sh[idx*5 +: 5];
    if (mask[idx] && ((c / b) % 2 == 1)) begin
      an  = 4'b1111;
      seg = 7'h7F;
    end else begin
      an      = 4'b1111;
      an[idx] = 1'b0;
      seg     = GLYPH_TAB[code];
    end
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_an0 = 4'hF; exp_seg0 = 7'h7F; c0 = 0; sh0 = '0;
      exp_an1 = 4'hF; exp_seg1 = 7'h7F; c1 = 0; sh1 = '0;
      model_valid = 1'b1;
    end else begin
      model_out(c0, R0, B0, sh0, blink_mask, exp_an0, exp_seg0);
      model_out(c1, R1, B1, sh1, blink_mask, exp_an1, exp_seg1);
      if (c0 % (4*R0) == 4*R0 - 1) sh0 = ssd;
      if (c1 % (4*R1) == 4*R1 - 1) sh1 = ssd;
      c0++;
      c1++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      chk("an_r4",  {28'd0, an0},  {28'd0, exp_an0});
      chk("seg_r4", {25'd0, seg0}, {25'd0, exp_seg0});
      chk("an_r1",  {28'd0, an1},  {28'd0, exp_an1});
      chk("seg_r1", {25'd0, seg1}, {25'd0, exp_seg1});
    end
  end

  task automatic wait_c(input int n);
    int k = 0;
    while (c0 != n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (c0 != n) chk("wait_cycle", 32'(c0), 32'(n));
  endtask

  task automatic pin(input string name, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    chk({name, "_an"},  {28'd0, an0},  {28'd0, an_exp});
    chk({name, "_seg"}, {25'd0, seg0}, {25'd0, seg_exp});
  endtask

  initial begin
    rst = 1'b1; ssd = '0; blink_mask = '0;
    repeat (3) @(negedge clk);
    pin("reset", 4'b1111, 7'h7F);
    chk("reset_r1_an", {28'd0, an1}, 32'hF);

    // Word {C, L, 5, d}; first frame still blank.
    ssd = {5'd13, 5'd14, 5'd5, 5'd16};
    rst = 1'b0;
    wait_c(5);  pin("blank_frame", 4'b1101, 7'h7F);
    wait_c(17); pin("frame2_d0", 4'b1110, 7'h21);
    wait_c(21); pin("frame2_d1", 4'b1101, 7'h12);
    wait_c(22); ssd = {4{5'd15}};
    wait_c(25); pin("midframe_d2", 4'b1011, 7'h47);
    wait_c(29); pin("midframe_d3", 4'b0111, 7'h46);
    wait_c(33); pin("dash_d0", 4'b1110, 7'h3F);

    // Blink digit 0 showing '1'.
    wait_c(34); ssd = 20'd1; blink_mask = 4'b0001;
    wait_c(49); pin("blink_off", 4'b1111, 7'h7F);
    wait_c(65); pin("blink_on", 4'b1110, 7'h79);

    // Codes 21 and 31 decode blank.
    wait_c(66); ssd = {5'd21, 5'd31, 5'd17, 5'd8}; blink_mask = 4'b0000;
    wait_c(81); pin("hi_d0", 4'b1110, 7'h00);
    wait_c(85); pin("hi_d1", 4'b1101, 7'h40);
    wait_c(89); pin("hi_d2", 4'b1011, 7'h7F);

    // Reset mid-scan while slot 2 is active.
    rst = 1'b1;
    @(negedge clk); pin("midscan_rst", 4'b1111, 7'h7F);
    rst = 1'b0;
    wait_c(1); pin("after_rst", 4'b1110, 7'h7F);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) ssd = 20'($urandom);
      if ($urandom_range(3) == 0) blink_mask = 4'($urandom);
      rst = ($urandom_range(499) == 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
